wctl_barrier_ctrl: RTL and testbench

- Barrier scheduler behind the warp-control unit.
- Consumes committed barrier operations (warp id, barrier id, size, no-op flag) from the warp-control commit path.
- Tracks arrivals per local barrier and holds arriving warps stalled.
- Releases all participants together when the last expected warp arrives. Exports a per-warp stall mask to the warp scheduler.

---
 rtl/wctl_barrier_ctrl_if.sv | 33 +++
 rtl/wctl_barrier_ctrl.sv | 126 ++++++++++++
 tb/tb_wctl_barrier_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wctl_barrier_ctrl_if.sv
// Request/abort bundle from the warp-control commit path and the barrier status
// returned to the warp scheduler.
interface wctl_barrier_ctrl_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_WIDTH     = $clog2(NUM_WARPS),
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
);
  logic                 req_valid;
  logic [NW_WIDTH-1:0]  req_wid;
  logic [NB_WIDTH-1:0]  req_id;
  logic [NW_WIDTH-1:0]  req_size_m1;
  logic                 req_is_noop;
  logic                 abort_valid;
  logic [NW_WIDTH-1:0]  abort_wid;
  logic [NUM_WARPS-1:0] stall_mask;
  logic                 release_valid;
  logic [NUM_WARPS-1:0] release_mask;
  logic                 busy;
  logic                 err_dup;

  modport master (
    output req_valid, req_wid, req_id, req_size_m1, req_is_noop,
    output abort_valid, abort_wid,
    input  stall_mask, release_valid, release_mask, busy, err_dup
  );

  modport slave (
    input  req_valid, req_wid, req_id, req_size_m1, req_is_noop,
    input  abort_valid, abort_wid,
    output stall_mask, release_valid, release_mask, busy, err_dup
  );
endinterface

// File: rtl/wctl_barrier_ctrl.sv
// Barrier scheduler: counts arrivals per local barrier slot, stalls arriving
// warps and releases all participants together on the last arrival.
module wctl_barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_WIDTH     = $clog2(NUM_WARPS),
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  wctl_barrier_ctrl_if.slave  bus
);

  typedef struct packed {
    logic                 active;
    logic [NW_WIDTH-1:0]  cnt;
    logic [NW_WIDTH-1:0]  size_m1;
    logic [NUM_WARPS-1:0] wmask;
  } slot_t;

  slot_t                slot_q [NUM_BARRIERS];
  slot_t                slot_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] stall_q, stall_d;
  logic [NUM_WARPS-1:0] rel_mask_q, rel_mask_d;
  logic                 rel_valid_q, rel_valid_d;
  logic                 busy_q, busy_d;
  logic                 dup_q, dup_d;

  logic [NB_WIDTH-1:0]  sel;
  logic [NUM_WARPS-1:0] wid_oh;
  logic                 req_live;
  slot_t                cur;

  assign sel    = bus.req_id;
  assign wid_oh = NUM_WARPS'(1) << bus.req_wid;
  // A warp killed in the same cycle it commits a barrier op never arrives.
  assign req_live = bus.req_valid &&
                    !(bus.abort_valid && (bus.abort_wid == bus.req_wid));

  // NOTE: blocking assignments here are intentional -- the request stage must
  // see the post-abort slot values computed a few lines earlier in this block.
  always_comb begin
    slot_d      = slot_q;
    rel_valid_d = 1'b0;
    rel_mask_d  = '0;
    dup_d       = 1'b0;
    cur         = '0;

    if (bus.abort_valid) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        if (slot_q[b].active && slot_q[b].wmask[bus.abort_wid]) begin
          if (slot_q[b].cnt == NW_WIDTH'(1)) begin
            slot_d[b] = '0;
          end else begin
            slot_d[b].wmask[bus.abort_wid] = 1'b0;
            slot_d[b].cnt                  = slot_q[b].cnt - NW_WIDTH'(1);
          end
        end
      end
    end

    if (req_live) begin
      if (bus.req_is_noop) begin
        rel_valid_d = 1'b1;
        rel_mask_d  = wid_oh;
      end else if (int'(sel) < NUM_BARRIERS) begin
        cur = slot_d[sel];
        if (cur.active && cur.wmask[bus.req_wid]) begin
          dup_d = 1'b1;
        end else if (!cur.active) begin
          if (bus.req_size_m1 == '0) begin
            rel_valid_d = 1'b1;
            rel_mask_d  = wid_oh;
          end else begin
            slot_d[sel].active  = 1'b1;
            slot_d[sel].cnt     = NW_WIDTH'(1);
            slot_d[sel].size_m1 = bus.req_size_m1;
            slot_d[sel].wmask   = wid_oh;
          end
        end else if (cur.cnt == cur.size_m1) begin
          rel_valid_d = 1'b1;
          rel_mask_d  = cur.wmask | wid_oh;
          slot_d[sel] = '0;
        end else begin
          slot_d[sel].cnt   = cur.cnt + NW_WIDTH'(1);
          slot_d[sel].wmask = cur.wmask | wid_oh;
        end
      end
    end

    // Stall mask is the union of waiting warps, so releases and aborts clear it.
    stall_d = '0;
    busy_d  = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stall_d = stall_d | slot_d[b].wmask;
      busy_d  = busy_d | slot_d[b].active;
    end
  end

  // NOTE: the slot array is a handful of flops, not a RAM, so it is reset
  // explicitly; a stale active bit after reset would stall warps forever.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) slot_q[b] <= '0;
      stall_q     <= '0;
      rel_valid_q <= 1'b0;
      rel_mask_q  <= '0;
      busy_q      <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) slot_q[b] <= slot_d[b];
      stall_q     <= stall_d;
      rel_valid_q <= rel_valid_d;
      rel_mask_q  <= rel_mask_d;
      busy_q      <= busy_d;
      dup_q       <= dup_d;
    end
  end

  assign bus.stall_mask    = stall_q;
  assign bus.release_valid = rel_valid_q;
  assign bus.release_mask  = rel_mask_q;
  assign bus.busy          = busy_q;
  assign bus.err_dup       = dup_q;

endmodule

// File: tb/tb_wctl_barrier_ctrl.sv
// Directed bench for wctl_barrier_ctrl: each task drives one scenario and
// compares the packed output bundle {rv, release_mask, stall_mask, busy, err_dup}.
module tb_wctl_barrier_ctrl;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  wctl_barrier_ctrl_if bus ();

  wctl_barrier_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {release_valid, release_mask, stall_mask, busy, err_dup}
  function automatic logic [10:0] obs();
    return {bus.release_valid, bus.release_mask, bus.stall_mask, bus.busy, bus.err_dup};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_valid   = 1'b0;
    bus.req_is_noop = 1'b0;
    bus.abort_valid = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] wid, input logic [1:0] id,
                         input logic [1:0] sm1, input logic noop);
    bus.req_valid   = 1'b1;
    bus.req_wid     = wid;
    bus.req_id      = id;
    bus.req_size_m1 = sm1;
    bus.req_is_noop = noop;
  endtask

  task automatic arrive(input logic [1:0] wid, input logic [1:0] id, input logic [1:0] sm1);
    set_req(wid, id, sm1, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    n_tests++;
    if (obs() !== 11'b0_0000_0000_0_0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b", obs(), 11'b0_0000_0000_0_0);
    end
  endtask

  task automatic test_basic();
    arrive(2'd1, 2'd0, 2'd2);
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_arr1 got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0});
    end
    arrive(2'd3, 2'd0, 2'd0);
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b1010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_arr2 got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b1010, 1'b1, 1'b0});
    end
    arrive(2'd0, 2'd0, 2'd3);
    n_tests++;
    if (obs() !== {1'b1, 4'b1011, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_release got=%b exp=%b", obs(), {1'b1, 4'b1011, 4'b0000, 1'b0, 1'b0});
    end
    tick();
    n_tests++;
    if (obs() !== 11'b0) begin
      n_fail++;
      $display("FAIL basic_pulse_end got=%b exp=%b", obs(), 11'b0);
    end
  endtask

  task automatic test_noop();
    arrive(2'd1, 2'd1, 2'd1);
    set_req(2'd2, 2'd1, 2'd3, 1'b1);
    tick();
    n_tests++;
    if (obs() !== {1'b1, 4'b0100, 4'b0010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL noop_release got=%b exp=%b", obs(), {1'b1, 4'b0100, 4'b0010, 1'b1, 1'b0});
    end
    arrive(2'd0, 2'd1, 2'd0);
    n_tests++;
    if (obs() !== {1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL noop_slot_intact got=%b exp=%b", obs(), {1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0});
    end
  endtask

  task automatic test_dup();
    arrive(2'd1, 2'd3, 2'd1);
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL dup_first got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0});
    end
    arrive(2'd1, 2'd3, 2'd1);
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b0010, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL dup_pulse got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b0010, 1'b1, 1'b1});
    end
    tick();
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL dup_pulse_end got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0});
    end
    arrive(2'd0, 2'd3, 2'd1);
    n_tests++;
    if (obs() !== {1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL dup_release got=%b exp=%b", obs(), {1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0});
    end
  endtask

  task automatic test_abort_concurrent();
    arrive(2'd0, 2'd2, 2'd3);
    arrive(2'd1, 2'd2, 2'd3);
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_setup got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0});
    end
    bus.abort_valid = 1'b1;
    bus.abort_wid   = 2'd1;
    arrive(2'd3, 2'd2, 2'd3);
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b1001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_with_arrival got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b1001, 1'b1, 1'b0});
    end
    // Count must be 2 here: one more arrival makes 3, the fourth releases.
    arrive(2'd2, 2'd2, 2'd3);
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b1101, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_cnt_check got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b1101, 1'b1, 1'b0});
    end
    arrive(2'd1, 2'd2, 2'd3);
    n_tests++;
    if (obs() !== {1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_final_release got=%b exp=%b", obs(), {1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0});
    end
  endtask

  task automatic test_abort_same_wid();
    arrive(2'd0, 2'd0, 2'd1);
    bus.abort_valid = 1'b1;
    bus.abort_wid   = 2'd0;
    arrive(2'd0, 2'd0, 2'd1);
    n_tests++;
    if (obs() !== 11'b0) begin
      n_fail++;
      $display("FAIL abort_same_wid got=%b exp=%b", obs(), 11'b0);
    end
  endtask

  task automatic test_size_zero();
    arrive(2'd3, 2'd1, 2'd0);
    n_tests++;
    if (obs() !== {1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL size_zero got=%b exp=%b", obs(), {1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0});
    end
  endtask

  task automatic test_interleave();
    arrive(2'd0, 2'd0, 2'd1);
    arrive(2'd1, 2'd1, 2'd1);
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL inter_two_slots got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0});
    end
    arrive(2'd2, 2'd1, 2'd1);
    n_tests++;
    if (obs() !== {1'b1, 4'b0110, 4'b0001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL inter_slot1_release got=%b exp=%b", obs(), {1'b1, 4'b0110, 4'b0001, 1'b1, 1'b0});
    end
    arrive(2'd3, 2'd0, 2'd1);
    n_tests++;
    if (obs() !== {1'b1, 4'b1001, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL inter_slot0_release got=%b exp=%b", obs(), {1'b1, 4'b1001, 4'b0000, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reset_mid_op();
    arrive(2'd0, 2'd1, 2'd3);
    arrive(2'd2, 2'd1, 2'd3);
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b0101, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_setup got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b0101, 1'b1, 1'b0});
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 11'b0) begin
      n_fail++;
      $display("FAIL midrst_async_clear got=%b exp=%b", obs(), 11'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    arrive(2'd1, 2'd1, 2'd1);
    n_tests++;
    if (obs() !== {1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_fresh_arr got=%b exp=%b", obs(), {1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0});
    end
    arrive(2'd3, 2'd1, 2'd1);
    n_tests++;
    if (obs() !== {1'b1, 4'b1010, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_fresh_release got=%b exp=%b", obs(), {1'b1, 4'b1010, 4'b0000, 1'b0, 1'b0});
    end
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    reset           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_wid     = '0;
    bus.req_id      = '0;
    bus.req_size_m1 = '0;
    bus.req_is_noop = 1'b0;
    bus.abort_valid = 1'b0;
    bus.abort_wid   = '0;
    #2;
    test_reset();
    #10;
    reset = 1'b1;
    test_basic();
    test_noop();
    test_dup();
    test_abort_concurrent();
    test_abort_same_wid();
    test_size_zero();
    test_interleave();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
